// File: rtl/router_dest_rx_if.sv
// router_dest_rx_if: read-side handshake between a router output-port FIFO and its reader.
// master = FIFO side (presents data/status, receives the read strobe)
// slave  = reader side (router_dest_rx)
interface router_dest_rx_if;
  logic       valid_out;
  logic       soft_reset;
  logic [7:0] data_out;
  logic       read_enb;

  modport master (
    output valid_out,
    output soft_reset,
    output data_out,
    input  read_enb
  );

  modport slave (
    input  valid_out,
    input  soft_reset,
    input  data_out,
    output read_enb
  );
endinterface

// File: rtl/router_dest_rx.sv
// router_dest_rx: destination-side reader for one router output port.
// Drains whole packets (header, payload bytes, parity byte) from the port FIFO,
// splits out length/address, streams the payload and checks parity.
// Optional mid-packet stall timeout: define RX_TIMEOUT_EN to enable it
// (default build waits indefinitely; abort only via soft_reset).
module router_dest_rx #(
  parameter int RD_DELAY = 0,
  parameter int TIMEOUT  = 32
) (
  input  logic             clock,
  input  logic             resetn,
  router_dest_rx_if.slave  fifo,
  output logic [5:0]       pkt_len,
  output logic [1:0]       pkt_addr,
  output logic [7:0]       rx_data,
  output logic             rx_data_vld,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             pkt_abort,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} state_t;

  localparam int               DLY_W    = (RD_DELAY > 1) ? $clog2(RD_DELAY + 1) : 1;
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(RD_DELAY);
  localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

  // RD_DELAY must expire well inside the router's soft-reset window.
  if (RD_DELAY < 0 || RD_DELAY >= 30) begin : g_bad_rd_delay
    $error("router_dest_rx: RD_DELAY must be in 0..29");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("router_dest_rx: TIMEOUT must be at least 1");
  end

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [6:0]       issued;     // reads issued for the current packet
  logic [6:0]       cap_cnt;    // bytes captured for the current packet
  logic [6:0]       len_ext;
  logic [6:0]       total;      // bytes to read: 2 until the header is known, then len+2
  logic             hdr_seen;
  logic [7:0]       acc;        // running XOR of header and payload
  logic             rd_fire_p0;
  logic             cap_vld_p1;
  logic             cap_hdr;
  logic             cap_pay;
  logic             cap_par;
  logic             tmo_hit;
  logic             abort;

  assign len_ext = {1'b0, pkt_len};
  // Before the header lands only header+parity are known to exist, so at most
  // one read is ever speculated past the header.
  assign total   = hdr_seen ? (len_ext + 7'd2) : 7'd2;
  assign abort   = (state != IDLE) && (fifo.soft_reset || tmo_hit);

  // The strobe follows valid_out combinationally so a starved FIFO stops reads in the same cycle.
  assign fifo.read_enb = (state == READ) && (issued < total) && fifo.valid_out && !abort;
  assign rd_fire_p0    = fifo.read_enb;

  // Byte classification on the capture stage: data_out is valid one cycle after the fire.
  assign cap_hdr = cap_vld_p1 && !hdr_seen;
  assign cap_pay = cap_vld_p1 && hdr_seen && (cap_cnt <= len_ext);
  assign cap_par = cap_vld_p1 && hdr_seen && (cap_cnt == (len_ext + 7'd1));

`ifdef RX_TIMEOUT_EN
  localparam int               TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  logic [TMO_W-1:0] stall_cnt;

  // Count starved cycles while a packet is open; any captured byte restarts the count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (((state != READ) && (state != DRAIN)) || abort || cap_vld_p1) begin
      stall_cnt <= '0;
    end else if (!fifo.valid_out) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign tmo_hit = (stall_cnt == TMO_MAX);
`else
  assign tmo_hit = 1'b0;
`endif

  // Packet sequencing, byte capture, parity check and status pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      issued      <= '0;
      cap_cnt     <= '0;
      hdr_seen    <= 1'b0;
      acc         <= '0;
      cap_vld_p1  <= 1'b0;
      pkt_len     <= '0;
      pkt_addr    <= '0;
      rx_data     <= '0;
      rx_data_vld <= 1'b0;
      pkt_done    <= 1'b0;
      parity_err  <= 1'b0;
      pkt_abort   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_data_vld <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_abort   <= 1'b0;

      if (abort) begin
        // Drop everything in flight; the last header fields stay visible.
        state      <= IDLE;
        busy       <= 1'b0;
        pkt_abort  <= 1'b1;
        parity_err <= 1'b0;
        cap_vld_p1 <= 1'b0;
        issued     <= '0;
        cap_cnt    <= '0;
        hdr_seen   <= 1'b0;
      end else begin
        // ---- p0 -> p1: read issued, byte arrives next cycle
        cap_vld_p1 <= rd_fire_p0;
        if (rd_fire_p0) begin
          issued <= issued + 7'd1;
        end

        // ---- p1: byte captured from data_out
        if (cap_vld_p1) begin
          cap_cnt <= cap_cnt + 7'd1;
        end
        if (cap_hdr) begin
          pkt_len  <= fifo.data_out[7:2];
          pkt_addr <= fifo.data_out[1:0];
          acc      <= fifo.data_out;
          hdr_seen <= 1'b1;
        end
        if (cap_pay) begin
          rx_data     <= fifo.data_out;
          rx_data_vld <= 1'b1;
          acc         <= acc ^ fifo.data_out;
        end

        case (state)
          IDLE: begin
            if (fifo.valid_out) begin
              busy    <= 1'b1;
              dly_cnt <= DLY_INIT;
              state   <= (RD_DELAY == 0) ? READ : WAIT;
            end
          end
          WAIT: begin
            // RD_DELAY cycles are spent outside IDLE before the first strobe.
            if (dly_cnt <= DLY_ONE) begin
              state <= READ;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end
          READ: begin
            if (issued == total) begin
              state <= DRAIN;
            end
          end
          default: begin
          end
        endcase

        // Parity byte closes the packet from READ (len=0) or DRAIN.
        if (cap_par) begin
          parity_err <= (acc != fifo.data_out);
          pkt_done   <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
          issued     <= '0;
          cap_cnt    <= '0;
          hdr_seen   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_dest_rx.sv
// tb_router_dest_rx: directed, table-driven bench for router_dest_rx.
// Two instances: u_dut (RD_DELAY=0) carries most traffic, u_dut_d4 (RD_DELAY=4)
// checks the start-up delay. Each has a simple FIFO model with a registered read port.
module tb_router_dest_rx;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  router_dest_rx_if bus0 ();
  router_dest_rx_if bus1 ();

  logic [5:0] len0, len1;
  logic [1:0] addr0, addr1;
  logic [7:0] rxd0, rxd1;
  logic       rxv0, rxv1, done0, done1, perr0, perr1, abt0, abt1, busy0, busy1;

  router_dest_rx #(.RD_DELAY(0), .TIMEOUT(32)) u_dut (
    .clock       (clock),
    .resetn      (resetn),
    .fifo        (bus0),
    .pkt_len     (len0),
    .pkt_addr    (addr0),
    .rx_data     (rxd0),
    .rx_data_vld (rxv0),
    .pkt_done    (done0),
    .parity_err  (perr0),
    .pkt_abort   (abt0),
    .busy        (busy0)
  );

  router_dest_rx #(.RD_DELAY(4), .TIMEOUT(32)) u_dut_d4 (
    .clock       (clock),
    .resetn      (resetn),
    .fifo        (bus1),
    .pkt_len     (len1),
    .pkt_addr    (addr1),
    .rx_data     (rxd1),
    .rx_data_vld (rxv1),
    .pkt_done    (done1),
    .parity_err  (perr1),
    .pkt_abort   (abt1),
    .busy        (busy1)
  );

  // FIFO models: byte store written by the stimulus, read pointer owned by the model.
  logic [7:0] mem0 [0:511];
  logic [7:0] mem1 [0:511];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
  logic f0_fire, f0_flush, f1_fire, f1_flush;

  always @(posedge clock) begin
    f0_fire  = bus0.read_enb && bus0.valid_out;
    f0_flush = !resetn || bus0.soft_reset;
    #1;
    if (f0_flush) rp0 = wp0;
    else if (f0_fire) begin
      bus0.data_out = mem0[rp0];
      rp0 = rp0 + 1;
    end
    bus0.valid_out = (rp0 != wp0);
  end

  always @(posedge clock) begin
    f1_fire  = bus1.read_enb && bus1.valid_out;
    f1_flush = !resetn || bus1.soft_reset;
    #1;
    if (f1_flush) rp1 = wp1;
    else if (f1_fire) begin
      bus1.data_out = mem1[rp1];
      rp1 = rp1 + 1;
    end
    bus1.valid_out = (rp1 != wp1);
  end

  // Monitor: event counters and payload log, sampled mid-cycle.
  int rd0 = 0, vld0 = 0, done0c = 0, abt0c = 0, bad_rd0 = 0;
  int rd1 = 0, vld1 = 0, done1c = 0, bad_rd1 = 0;
  logic [7:0] rxlog0 [0:511];
  logic perr_at_done0 = 1'b0;

  always @(negedge clock) begin
    if (bus0.read_enb && bus0.valid_out) rd0++;
    if (bus0.read_enb && !bus0.valid_out) bad_rd0++;
    if (rxv0) begin rxlog0[vld0] = rxd0; vld0++; end
    if (done0) begin done0c++; perr_at_done0 = perr0; end
    if (abt0) abt0c++;
    if (bus1.read_enb && bus1.valid_out) rd1++;
    if (bus1.read_enb && !bus1.valid_out) bad_rd1++;
    if (rxv1) vld1++;
    if (done1) done1c++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push0(input logic [7:0] b);
    mem0[wp0] = b;
    wp0 = wp0 + 1;
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wp1] = b;
    wp1 = wp1 + 1;
  endtask

  task automatic wait_done0(input int target, input string tag);
    int n;
    n = 0;
    while (done0c < target && n < 300) begin
      step(1);
      n++;
    end
    chk({tag, " pkt_done seen"}, (done0c >= target), 1);
  endtask

  typedef struct {
    logic [7:0]      hdr;
    logic [3:0][7:0] pay;    // pay[0] is the first payload byte
    logic [7:0]      par;
    int              n_pay;  // equals hdr[7:2]
    int              exp_addr;
    int              exp_perr;
  } vec_t;

  vec_t vecs [7];

  task automatic send0(input vec_t v);
    push0(v.hdr);
    for (int j = 0; j < v.n_pay; j++) push0(v.pay[j]);
    push0(v.par);
  endtask

  task automatic run_vec0(input vec_t v, input string tag);
    int b_rd, b_v, b_d;
    b_rd = rd0; b_v = vld0; b_d = done0c;
    send0(v);
    wait_done0(b_d + 1, tag);
    step(2);
    chk({tag, " pkt_len"}, len0, v.n_pay);
    chk({tag, " pkt_addr"}, addr0, v.exp_addr);
    chk({tag, " parity_err@done"}, perr_at_done0, v.exp_perr);
    chk({tag, " parity_err held"}, perr0, v.exp_perr);
    chk({tag, " vld count"}, vld0 - b_v, v.n_pay);
    chk({tag, " reads"}, rd0 - b_rd, v.n_pay + 2);
    chk({tag, " busy idle"}, busy0, 0);
    for (int j = 0; j < v.n_pay; j++)
      chk($sformatf("%s rx_data[%0d]", tag, j), rxlog0[b_v + j], v.pay[j]);
  endtask

  initial begin
    int b_rd, b_v, b_d, b_a, n, cnt_wait, rd_hi;
    logic got_rd;

    bus0.soft_reset = 1'b0;
    bus1.soft_reset = 1'b0;

    vecs[0] = '{hdr:8'h0D, pay:{8'h00, 8'h33, 8'h22, 8'h11}, par:8'h0D, n_pay:3, exp_addr:1, exp_perr:0};
    vecs[1] = '{hdr:8'h0D, pay:{8'h00, 8'h33, 8'h22, 8'h11}, par:8'h0C, n_pay:3, exp_addr:1, exp_perr:1};
    vecs[2] = '{hdr:8'h0D, pay:{8'h00, 8'h33, 8'h22, 8'h11}, par:8'h0D, n_pay:3, exp_addr:1, exp_perr:0};
    vecs[3] = '{hdr:8'h00, pay:{8'h00, 8'h00, 8'h00, 8'h00}, par:8'h00, n_pay:0, exp_addr:0, exp_perr:0};
    vecs[4] = '{hdr:8'h0A, pay:{8'h00, 8'h00, 8'h5A, 8'hA5}, par:8'hF5, n_pay:2, exp_addr:2, exp_perr:0};
    vecs[5] = '{hdr:8'h11, pay:{8'h08, 8'h04, 8'h02, 8'h01}, par:8'h1E, n_pay:4, exp_addr:1, exp_perr:0};
    vecs[6] = '{hdr:8'h07, pay:{8'h00, 8'h00, 8'h00, 8'hFF}, par:8'h00, n_pay:1, exp_addr:3, exp_perr:1};

    // Reset state
    step(3);
    chk("reset read_enb", bus0.read_enb, 0);
    chk("reset busy", busy0, 0);
    chk("reset pkt_len", len0, 0);
    chk("reset pkt_addr", addr0, 0);
    chk("reset rx_data", rxd0, 0);
    chk("reset rx_data_vld", rxv0, 0);
    chk("reset pkt_done", done0, 0);
    chk("reset parity_err", perr0, 0);
    chk("reset pkt_abort", abt0, 0);
    resetn = 1'b1;
    step(2);

    // Table of whole packets
    for (int i = 0; i < 7; i++) run_vec0(vecs[i], $sformatf("vec%0d", i));

    // soft_reset after the first payload byte (parity_err is 1 from the last vector)
    b_v = vld0; b_d = done0c; b_a = abt0c;
    send0(vecs[0]);
    n = 0;
    while (vld0 == b_v && n < 60) begin step(1); n++; end
    chk("sr first payload seen", (vld0 > b_v), 1);
    bus0.soft_reset = 1'b1;
    step(1);
    bus0.soft_reset = 1'b0;
    chk("sr pkt_abort pulse", abt0, 1);
    chk("sr read_enb", bus0.read_enb, 0);
    chk("sr busy", busy0, 0);
    chk("sr parity_err cleared", perr0, 0);
    chk("sr pkt_len kept", len0, 3);
    chk("sr pkt_addr kept", addr0, 1);
    step(4);
    chk("sr no pkt_done", done0c - b_d, 0);
    chk("sr one abort", abt0c - b_a, 1);
    run_vec0(vecs[4], "after_sr");

    // valid_out gap after the second payload byte
    b_rd = rd0; b_v = vld0; b_d = done0c;
    push0(8'h0D); push0(8'h11); push0(8'h22);
    n = 0;
    while ((rd0 - b_rd) < 3 && n < 60) begin step(1); n++; end
    rd_hi = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (bus0.read_enb) rd_hi++;
    end
    chk("gap read_enb low", rd_hi, 0);
    chk("gap busy held", busy0, 1);
    chk("gap reads so far", rd0 - b_rd, 3);
    push0(8'h33); push0(8'h0D);
    wait_done0(b_d + 1, "gap");
    step(2);
    chk("gap parity_err", perr0, 0);
    chk("gap reads", rd0 - b_rd, 5);
    chk("gap vld count", vld0 - b_v, 3);
    chk("gap rx0", rxlog0[b_v], 8'h11);
    chk("gap rx1", rxlog0[b_v + 1], 8'h22);
    chk("gap rx2", rxlog0[b_v + 2], 8'h33);

    // Back-to-back packets
    b_rd = rd0; b_v = vld0; b_d = done0c;
    send0(vecs[0]);
    send0(vecs[3]);
    n = 0;
    while (done0 !== 1'b1 && n < 60) begin step(1); n++; end
    chk("b2b first done", done0, 1);
    chk("b2b idle at done", busy0, 0);
    step(1);
    chk("b2b busy next cycle", busy0, 1);
    wait_done0(b_d + 2, "b2b");
    step(2);
    chk("b2b pkt_len", len0, 0);
    chk("b2b parity_err", perr0, 0);
    chk("b2b reads", rd0 - b_rd, 7);
    chk("b2b vld count", vld0 - b_v, 3);

    // RD_DELAY=4 instance: first strobe RD_DELAY cycles after leaving IDLE
    push1(8'h00); push1(8'h00);
    n = 0; cnt_wait = 0; got_rd = 1'b0;
    while (!got_rd && n < 60) begin
      step(1); n++;
      if (bus1.read_enb === 1'b1) got_rd = 1'b1;
      else if (busy1 === 1'b1) cnt_wait++;
    end
    chk("d4 read seen", got_rd, 1);
    chk("d4 wait cycles", cnt_wait, 4);
    n = 0;
    while (done1c < 1 && n < 60) begin step(1); n++; end
    chk("d4 pkt_done", done1c, 1);
    step(2);
    chk("d4 no rx_data_vld", vld1, 0);
    chk("d4 pkt_len", len1, 0);
    chk("d4 parity_err", perr1, 0);
    chk("d4 reads", rd1, 2);

    // Mid-payload starvation
    b_v = vld0; b_d = done0c; b_a = abt0c;
    push0(8'h0D); push0(8'h11);
    step(30);
    chk("stall no early abort", abt0c - b_a, 0);
    step(70);
`ifdef RX_TIMEOUT_EN
    chk("stall timeout abort", abt0c - b_a, 1);
    chk("stall timeout idle", busy0, 0);
`else
    chk("stall no abort", abt0c - b_a, 0);
    chk("stall still busy", busy0, 1);
    push0(8'h22); push0(8'h33); push0(8'h0D);
    wait_done0(b_d + 1, "stall");
    step(2);
    chk("stall parity_err", perr0, 0);
    chk("stall vld count", vld0 - b_v, 3);
    chk("stall rx2", rxlog0[b_v + 2], 8'h33);
`endif
    chk("stall no pkt_done early", (done0c - b_d) <= 1, 1);

    // Asynchronous reset mid-packet
    b_rd = rd0; b_d = done0c; b_a = abt0c;
    send0(vecs[0]);
    n = 0;
    while ((rd0 - b_rd) < 3 && n < 60) begin step(1); n++; end
    resetn = 1'b0;
    #1;
    chk("areset busy", busy0, 0);
    chk("areset pkt_len", len0, 0);
    chk("areset read_enb", bus0.read_enb, 0);
    chk("areset rx_data_vld", rxv0, 0);
    step(3);
    resetn = 1'b1;
    step(3);
    chk("areset no pkt_done", done0c - b_d, 0);
    chk("areset no abort", abt0c - b_a, 0);
    run_vec0(vecs[5], "after_areset");

    chk("no read_enb without valid_out (dut)", bad_rd0, 0);
    chk("no read_enb without valid_out (d4)", bad_rd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
